// File: rtl/ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_seq_pkg
// Description : Shared types and helpers for control_sequencer: FSM state
//               enum, opcode class encodings, register-file indices and
//               the opcode class extraction function.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU = 2'b00,
        CLS_MEM = 2'b01,
        CLS_BR  = 2'b10,
        CLS_SYS = 2'b11
    } cls_t;

    localparam int REG_PC = 0;
    localparam int REG_IR = 1;
    localparam int REG_A  = 2;

    // Class lives in the two most significant opcode bits; the opcode is
    // passed zero-extended so one function serves every OPCODE_W.
    function automatic cls_t get_class(input logic [31:0] op, input int w);
        logic [31:0] t;
        t = op >> (w - 2);
        return cls_t'(t[1:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_seq_watchdog
// Description : Memory wait-state counter with terminal-count compare. The
//               count runs while the sequencer is stalled on MEM_READY and
//               clears whenever it is not.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_seq_watchdog #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic timeout
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Count consecutive stalled cycles; any non-stalled cycle (state entry,
    // or the MEM_READY cycle that leaves the state) clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (waiting) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= '0;
        end
    end

    // Fires on the stalled cycle whose increment would reach the limit, so
    // a MEM_READY in that same cycle (waiting=0) always wins.
    assign timeout = waiting && (count == CNT_W'(MEM_TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Multi-cycle control-bus FSM (fetch/decode/exec/mem/wb) with
//               memory wait-state handshake, conditional branch and HALT.
//               Build macro CTRL_SEQ_TIMEOUT_EN adds the memory-timeout
//               watchdog and makes the FAULT state reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int FLAG_W      = 4,
    parameter int NUM_REGS    = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ENABLE,
    input  logic [OPCODE_W-1:0]         OPCODE,
    input  logic [FLAG_W-1:0]           FLAGS,
    input  logic                        MEM_READY,
    output logic                        RD_EN,
    output logic                        WR_EN,
    output logic                        INC_PC,
    output logic                        LOAD_REG,
    output logic                        MODE,
    output logic                        MUX_SELECT_A,
    output logic                        MUX_SELECT_B,
    output logic [$clog2(NUM_REGS)-1:0] LOAD_SELECT,
    output logic                        HALTED,
    output logic                        FAULT
);

    localparam int SEL_W  = $clog2(NUM_REGS);
    localparam int FIDX_W = $clog2(FLAG_W);

    state_t             state;
    logic               mem_store;
    logic               timeout;
    cls_t               cls;
    logic               is_halt;
    logic               br_taken;
    logic [FIDX_W-1:0]  flag_idx;
    state_t             boundary;

    assign cls      = get_class(32'(OPCODE), OPCODE_W);
    assign is_halt  = (cls == CLS_SYS) && (&OPCODE);
    assign flag_idx = OPCODE[FIDX_W-1:0];
    assign br_taken = (32'(flag_idx) < FLAG_W) && FLAGS[flag_idx];
    assign boundary = ENABLE ? ST_FETCH : ST_IDLE;

`ifdef CTRL_SEQ_TIMEOUT_EN
    logic waiting;
    assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !MEM_READY;

    ctrl_seq_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk     (CLK),
        .rst     (RST),
        .waiting (waiting),
        .timeout (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Sequencer state plus the memory direction captured in EXEC so the
    // strobe stays stable for the whole access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            mem_store <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:   if (ENABLE) state <= ST_FETCH;
                ST_FETCH: begin
                    if (MEM_READY)    state <= ST_DECODE;
                    else if (timeout) state <= ST_FAULT;
                end
                ST_DECODE: state <= ST_EXEC;
                ST_EXEC: begin
                    if (cls == CLS_MEM) begin
                        state     <= ST_MEM;
                        mem_store <= OPCODE[0];
                    end else if (is_halt) begin
                        state <= ST_HALT;
                    end else begin
                        state <= boundary;
                    end
                end
                ST_MEM: begin
                    if (MEM_READY)    state <= mem_store ? boundary : ST_WB;
                    else if (timeout) state <= ST_FAULT;
                end
                ST_WB:     state <= boundary;
                ST_HALT:   state <= ST_HALT;
                ST_FAULT:  state <= ST_FAULT;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    logic fault_state;

    // Control bus decode: state alone, except EXEC which also looks at the
    // opcode and flags.
    always_comb begin
        RD_EN        = 1'b0;
        WR_EN        = 1'b0;
        INC_PC       = 1'b0;
        LOAD_REG     = 1'b0;
        MODE         = 1'b0;
        MUX_SELECT_A = 1'b0;
        MUX_SELECT_B = 1'b0;
        LOAD_SELECT  = '0;
        HALTED       = 1'b0;
        fault_state  = 1'b0;
        case (state)
            ST_FETCH: begin
                RD_EN       = 1'b1;
                LOAD_SELECT = SEL_W'(REG_IR);
            end
            ST_DECODE: begin
                LOAD_REG    = 1'b1;
                LOAD_SELECT = SEL_W'(REG_IR);
                INC_PC      = 1'b1;
            end
            ST_EXEC: begin
                if (cls == CLS_ALU) begin
                    LOAD_REG     = 1'b1;
                    LOAD_SELECT  = SEL_W'(NUM_REGS - 1);
                    MODE         = OPCODE[2];
                    MUX_SELECT_A = OPCODE[1];
                    MUX_SELECT_B = OPCODE[0];
                end else if ((cls == CLS_BR) && br_taken) begin
                    LOAD_REG    = 1'b1;
                    LOAD_SELECT = SEL_W'(REG_PC);
                end
            end
            ST_MEM: begin
                RD_EN = !mem_store;
                WR_EN = mem_store;
            end
            ST_WB: begin
                LOAD_REG    = 1'b1;
                LOAD_SELECT = SEL_W'(REG_A);
            end
            ST_HALT:  HALTED      = 1'b1;
            ST_FAULT: fault_state = 1'b1;
            default: begin
            end
        endcase
    end

`ifdef CTRL_SEQ_TIMEOUT_EN
    assign FAULT = fault_state;
`else
    assign FAULT = 1'b0;
    logic unused_fault_state;
    assign unused_fault_state = fault_state;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. A transaction
//               model expands each instruction into its expected per-cycle
//               control-bus trace, which is compared cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic       CLK;
    logic       RST;
    logic       ENABLE;
    logic [4:0] OPCODE;
    logic [3:0] FLAGS;
    logic       MEM_READY;
    logic       RD_EN, WR_EN, INC_PC, LOAD_REG, MODE, MUX_SELECT_A, MUX_SELECT_B;
    logic [2:0] LOAD_SELECT;
    logic       HALTED, FAULT;

    control_sequencer #(
        .OPCODE_W    (5),
        .FLAG_W      (4),
        .NUM_REGS    (5),
        .MEM_TIMEOUT (15)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ENABLE       (ENABLE),
        .OPCODE       (OPCODE),
        .FLAGS        (FLAGS),
        .MEM_READY    (MEM_READY),
        .RD_EN        (RD_EN),
        .WR_EN        (WR_EN),
        .INC_PC       (INC_PC),
        .LOAD_REG     (LOAD_REG),
        .MODE         (MODE),
        .MUX_SELECT_A (MUX_SELECT_A),
        .MUX_SELECT_B (MUX_SELECT_B),
        .LOAD_SELECT  (LOAD_SELECT),
        .HALTED       (HALTED),
        .FAULT        (FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] out;
        bit          ready;
        string       tag;
    } step_t;

    step_t q[$];
    int    passes = 0;
    int    total  = 0;

    // Expected bus vector: {RD,WR,INC,LD,MODE,MA,MB,SEL[2:0],HALTED,FAULT}
    function automatic logic [11:0] mk(input bit rd, input bit wr, input bit inc,
                                       input bit ld, input bit mode, input bit ma,
                                       input bit mb, input int sel, input bit h,
                                       input bit f);
        logic [2:0] s;
        s = sel[2:0];
        return {rd, wr, inc, ld, mode, ma, mb, s, h, f};
    endfunction

    task automatic check(input string tag, input logic [11:0] exp);
        logic [11:0] got;
        got = {RD_EN, WR_EN, INC_PC, LOAD_REG, MODE, MUX_SELECT_A, MUX_SELECT_B,
               LOAD_SELECT, HALTED, FAULT};
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    endtask

    // Instruction-level model: what the bus must show on each cycle of one
    // instruction given its fetch and memory wait states.
    task automatic build(input logic [4:0] op, input logic [3:0] fl,
                         input int fw, input int mw);
        logic [1:0] cls;
        logic [1:0] idx;
        bit         st;
        cls = op[4:3];
        idx = op[1:0];
        st  = op[0];
        q.delete();
        for (int i = 0; i < fw; i++)
            q.push_back('{mk(1,0,0,0,0,0,0,1,0,0), 1'b0, "fetch_wait"});
        q.push_back('{mk(1,0,0,0,0,0,0,1,0,0), 1'b1, "fetch"});
        q.push_back('{mk(0,0,1,1,0,0,0,1,0,0), 1'($urandom), "decode"});
        case (cls)
            2'b00: q.push_back('{mk(0,0,0,1,op[2],op[1],op[0],4,0,0), 1'($urandom), "exec_alu"});
            2'b10: q.push_back('{fl[idx] ? mk(0,0,0,1,0,0,0,0,0,0) : 12'd0,
                                 1'($urandom), "exec_branch"});
            2'b01: begin
                q.push_back('{12'd0, 1'($urandom), "exec_mem"});
                for (int i = 0; i < mw; i++)
                    q.push_back('{mk(!st,st,0,0,0,0,0,0,0,0), 1'b0, "mem_wait"});
                q.push_back('{mk(!st,st,0,0,0,0,0,0,0,0), 1'b1, "mem"});
                if (!st) q.push_back('{mk(0,0,0,1,0,0,0,2,0,0), 1'($urandom), "writeback"});
            end
            default: q.push_back('{12'd0, 1'($urandom), "exec_sys"});
        endcase
    endtask

    // Play the first `limit` model steps; drop ENABLE at step `drop_at`.
    task automatic run(input logic [4:0] op, input logic [3:0] fl,
                       input int drop_at, input int limit);
        for (int i = 0; i < q.size() && i < limit; i++) begin
            @(negedge CLK);
            OPCODE    = op;
            FLAGS     = fl;
            MEM_READY = q[i].ready;
            if (i == drop_at) ENABLE = 1'b0;
            #1 check(q[i].tag, q[i].out);
        end
    endtask

    task automatic instr(input logic [4:0] op, input logic [3:0] fl,
                         input int fw, input int mw);
        build(op, fl, fw, mw);
        run(op, fl, -1, 1000);
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        ENABLE    = 1'b0;
        MEM_READY = 1'b0;
        repeat (2) @(negedge CLK);
        #1 check("reset_state", 12'd0);
        RST = 1'b0;
    endtask

    task automatic start();
        @(negedge CLK);
        ENABLE = 1'b1;
        #1 check("idle", 12'd0);
    endtask

    initial begin
        logic [4:0] op;
        logic [3:0] fl;
        OPCODE = 5'd0;
        FLAGS  = 4'd0;
        do_reset();
        start();

        // Directed instructions
        instr(5'b00110, 4'b0000, 0, 0);
        instr(5'b00110, 4'b0000, 0, 0);
        instr(5'b01000, 4'b0000, 0, 2);
        instr(5'b10010, 4'b0100, 0, 0);
        instr(5'b10010, 4'b0000, 0, 0);
        instr(5'b01001, 4'b0000, 1, 1);
        instr(5'b11000, 4'b1111, 0, 0);

        // Randomized instruction stream (HALT excluded)
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom);
            if (op == 5'b11111) op = 5'b11110;
            fl = 4'($urandom);
            instr(op, fl, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // ENABLE dropped during a store: store completes, then IDLE
        build(5'b01001, 4'd0, 0, 2);
        run(5'b01001, 4'd0, 2, 1000);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            MEM_READY = 1'($urandom);
            #1 check("idle_after_drop", 12'd0);
        end

        // Asynchronous reset in the middle of a store access
        start();
        build(5'b01001, 4'd0, 0, 6);
        run(5'b01001, 4'd0, -1, 5);
        #1 RST = 1'b1;
        ENABLE = 1'b0;
        #1 check("rst_async", 12'd0);
        @(negedge CLK);
        #1 check("rst_hold", 12'd0);
        RST = 1'b0;
        @(negedge CLK);
        #1 check("idle_after_rst", 12'd0);
        ENABLE    = 1'b1;
        MEM_READY = 1'b0;
        @(negedge CLK);
        #1 check("fetch_after_rst", mk(1,0,0,0,0,0,0,1,0,0));
        do_reset();

`ifdef CTRL_SEQ_TIMEOUT_EN
        // Fetch stalled: FAULT after 15 wait cycles, sticky
        start();
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            MEM_READY = 1'b0;
            #1 check("fetch_stall", mk(1,0,0,0,0,0,0,1,0,0));
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            ENABLE    = 1'($urandom);
            MEM_READY = 1'($urandom);
            #1 check("fault_sticky", mk(0,0,0,0,0,0,0,0,0,1));
        end
        do_reset();
        // Ready arriving on the 15th cycle rescues the access
        start();
        instr(5'b00001, 4'd0, 14, 0);
        instr(5'b01000, 4'd0, 0, 14);
        do_reset();
`else
        // Without the watchdog a long stall just keeps waiting
        start();
        instr(5'b00001, 4'd0, 40, 0);
        instr(5'b01001, 4'd0, 0, 30);
        do_reset();
`endif

        // HALT is sticky regardless of ENABLE and MEM_READY
        start();
        instr(5'b11111, 4'd0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            @(negedge CLK);
            ENABLE    = 1'($urandom);
            MEM_READY = 1'($urandom);
            #1 check("halted", mk(0,0,0,0,0,0,0,0,1,0));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
